// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 2**swidth:1 mux: visits enabled channels in ascending order and streams the samples out.
// Optional SCAN_PARITY_EN adds out_par, the even parity of the captured sample.
module mux_scan_ctrl #(
  parameter int width  = 4,
  parameter int swidth = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 stop,
  input  logic [2**swidth-1:0] ch_mask,
  output logic [swidth-1:0]    sel,
  input  logic [width-1:0]     mux_o,
  output logic [width-1:0]     out_data,
  output logic [swidth-1:0]    out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
`ifdef SCAN_PARITY_EN
  ,
  output logic                 out_par
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // SEEK  | testing channel sel, capturing it if enabled
  // HOLD  | sample presented, waiting for the handshake
  typedef enum logic [1:0] {IDLE, SEEK, HOLD} state_t;

  localparam int nch = 2**swidth;
  localparam logic [swidth-1:0] last_ch = swidth'(nch - 1);

  state_t           state;
  logic [nch-1:0]   mask_q;
  logic             mode_q;
  logic             stop_req;
  logic             adv;
  logic             scan_end;

  assign adv = ((state == SEEK) && !mask_q[sel]) ||
               ((state == HOLD) && out_valid && out_ready);

  // A pending stop ends the scan at the next advance; an empty mask never loops.
  assign scan_end = stop_req ||
                    ((sel == last_ch) && (!mode_q || (mask_q == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stop_req  <= 1'b0;
      mask_q    <= '0;
      mode_q    <= 1'b0;
`ifdef SCAN_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask_q <= ch_mask;
            mode_q <= mode;
            sel    <= '0;
            busy   <= 1'b1;
            state  <= SEEK;
          end
        end
        SEEK: begin
          if (mask_q[sel]) begin
            out_data  <= mux_o;
            out_ch    <= sel;
            out_valid <= 1'b1;
`ifdef SCAN_PARITY_EN
            out_par   <= ^mux_o;
`endif
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if ((state != IDLE) && stop) stop_req <= 1'b1;

      // sel+1 wraps naturally to channel 0 for the continuous case.
      if (adv) begin
        if (scan_end) begin
          sel      <= '0;
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          stop_req <= 1'b0;
        end else begin
          sel   <= sel + 1'b1;
          state <= SEEK;
        end
      end
    end
  end

endmodule
